// File: rtl/sccomp_dataflow.sv
// rtl/sccomp_dataflow.sv - single-cycle MIPS-subset SoC top with instruction and data RAMs.
// Optional macro BRANCH_EXT_EN adds blez/bgtz/bltz/bgez decode.

module sccomp_iram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);
  logic [31:0] inst_array [DEPTH];

  // Write port exists only so bring-up logic can load code; the core never writes here.
  always_ff @(posedge clk) begin
    if (load_en) inst_array[load_addr] <= load_data;
  end

  assign rdata = inst_array[addr];
endmodule

module sccomp_dram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] data_array [DEPTH];

  always_ff @(posedge clk) begin
    if (we) data_array[addr] <= wdata;
  end

  assign rdata = data_array[addr];
endmodule

module sccomp_dataflow #(
  parameter int          IMEM_DEPTH = 1024,
  parameter int          DMEM_DEPTH = 1024,
  parameter logic [31:0] RESET_PC   = 32'h0040_0000
) (
  input  logic        clk_in,
  input  logic        reset,
  output logic [31:0] inst,
  output logic [31:0] pc
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);

  logic [31:0] gpr [32];

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [25:0] target;
  logic [31:0] rs_val, rt_val, sext, zext, pc4, br_tgt, jmp_tgt;
  logic [31:0] mem_addr, mem_rdata;
  logic [31:0] next_pc, wr_data;
  logic [4:0]  wr_addr;
  logic        wr_en, mem_we;
  logic        unused_addr;

  sccomp_iram #(.DEPTH(IMEM_DEPTH), .AW(IAW)) iram_inst (
    .clk       (clk_in),
    .load_en   (1'b0),
    .load_addr ('0),
    .load_data (32'd0),
    .addr      (pc[IAW+1:2]),
    .rdata     (inst)
  );

  // Stores are suppressed while reset is held so preloaded data survives it.
  sccomp_dram #(.DEPTH(DMEM_DEPTH), .AW(DAW)) dram_inst (
    .clk   (clk_in),
    .we    (mem_we && !reset),
    .addr  (mem_addr[DAW+1:2]),
    .wdata (rt_val),
    .rdata (mem_rdata)
  );

  assign op     = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign shamt  = inst[10:6];
  assign funct  = inst[5:0];
  assign target = inst[25:0];

  assign rs_val   = (rs == 5'd0) ? 32'd0 : gpr[rs];
  assign rt_val   = (rt == 5'd0) ? 32'd0 : gpr[rt];
  assign sext     = {{16{inst[15]}}, inst[15:0]};
  assign zext     = {16'd0, inst[15:0]};
  assign pc4      = pc + 32'd4;
  assign br_tgt   = pc4 + {sext[29:0], 2'b00};
  assign jmp_tgt  = {pc4[31:28], target, 2'b00};
  assign mem_addr = rs_val + sext;

  assign unused_addr = ^{mem_addr[31:DAW+2], mem_addr[1:0]};

  always_comb begin
    wr_en   = 1'b0;
    wr_addr = rt;
    wr_data = 32'd0;
    mem_we  = 1'b0;
    next_pc = pc4;
    case (op)
      6'h00: begin
        wr_addr = rd;
        wr_en   = 1'b1;
        case (funct)
          6'h21: wr_data = rs_val + rt_val;
          6'h23: wr_data = rs_val - rt_val;
          6'h24: wr_data = rs_val & rt_val;
          6'h25: wr_data = rs_val | rt_val;
          6'h26: wr_data = rs_val ^ rt_val;
          6'h27: wr_data = ~(rs_val | rt_val);
          6'h2a: wr_data = {31'd0, $signed(rs_val) < $signed(rt_val)};
          6'h2b: wr_data = {31'd0, rs_val < rt_val};
          6'h00: wr_data = rt_val << shamt;
          6'h02: wr_data = rt_val >> shamt;
          6'h03: wr_data = 32'($signed(rt_val) >>> shamt);
          6'h04: wr_data = rt_val << rs_val[4:0];
          6'h06: wr_data = rt_val >> rs_val[4:0];
          6'h07: wr_data = 32'($signed(rt_val) >>> rs_val[4:0]);
          6'h08: begin
            wr_en   = 1'b0;
            next_pc = rs_val;
          end
          default: wr_en = 1'b0;
        endcase
      end
      6'h09: begin wr_en = 1'b1; wr_data = rs_val + sext; end
      6'h0c: begin wr_en = 1'b1; wr_data = rs_val & zext; end
      6'h0d: begin wr_en = 1'b1; wr_data = rs_val | zext; end
      6'h0e: begin wr_en = 1'b1; wr_data = rs_val ^ zext; end
      6'h0f: begin wr_en = 1'b1; wr_data = {inst[15:0], 16'd0}; end
      6'h0a: begin wr_en = 1'b1; wr_data = {31'd0, $signed(rs_val) < $signed(sext)}; end
      6'h0b: begin wr_en = 1'b1; wr_data = {31'd0, rs_val < sext}; end
      6'h23: begin wr_en = 1'b1; wr_data = mem_rdata; end
      6'h2b: mem_we = 1'b1;
      6'h04: if (rs_val == rt_val) next_pc = br_tgt;
      6'h05: if (rs_val != rt_val) next_pc = br_tgt;
      6'h02: next_pc = jmp_tgt;
      6'h03: begin
        next_pc = jmp_tgt;
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = pc4;
      end
`ifdef BRANCH_EXT_EN
      6'h01: begin
        if (rt == 5'd0 && rs_val[31]) next_pc = br_tgt;
        if (rt == 5'd1 && !rs_val[31]) next_pc = br_tgt;
      end
      6'h06: if (rs_val[31] || rs_val == 32'd0) next_pc = br_tgt;
      6'h07: if (!rs_val[31] && rs_val != 32'd0) next_pc = br_tgt;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int i = 0; i < 32; i++) gpr[i] <= 32'd0;
    end else begin
      pc <= next_pc;
      if (wr_en && wr_addr != 5'd0) gpr[wr_addr] <= wr_data;
    end
  end
endmodule

// File: tb/tb_sccomp_dataflow.sv
// tb/tb_sccomp_dataflow.sv - ISA-level model bench for sccomp_dataflow: directed program then random code.

module tb_sccomp_dataflow;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam logic [5:0] RFUN [15] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b,
                                       6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h08};
  localparam logic [5:0] IOP [15] = '{6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h0a, 6'h0b, 6'h23,
                                      6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h06, 6'h07};

  logic        clk_in;
  logic        reset;
  logic [31:0] inst;
  logic [31:0] pc;

  logic [31:0] m_pc;
  logic [31:0] m_gpr [32];
  logic [31:0] m_imem [1024];
  logic [31:0] m_dmem [1024];
  logic        cmp_en;
  int          checks;
  int          errors;

  sccomp_dataflow dut (
    .clk_in (clk_in),
    .reset  (reset),
    .inst   (inst),
    .pc     (pc)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] slt_u(input logic [31:0] x, input logic [31:0] y);
    return (x < y) ? 32'd1 : 32'd0;
  endfunction

  // Signed compare done by flipping sign bits and comparing unsigned.
  function automatic logic [31:0] slt_s(input logic [31:0] x, input logic [31:0] y);
    return slt_u(x ^ 32'h8000_0000, y ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] shr_a(input logic [31:0] x, input logic [4:0] s);
    return (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
  endfunction

  task automatic model_tick(input logic rst);
    logic [31:0] w, a, b, se, ze, ea, npc, wd;
    logic [4:0]  wa;
    if (rst) begin
      m_pc = RPC;
      for (int r = 0; r < 32; r++) m_gpr[r] = 32'd0;
      return;
    end
    w   = m_imem[m_pc[11:2]];
    a   = m_gpr[w[25:21]];
    b   = m_gpr[w[20:16]];
    se  = {{16{w[15]}}, w[15:0]};
    ze  = {16'd0, w[15:0]};
    ea  = a + se;
    npc = m_pc + 32'd4;
    wa  = 5'd0;
    wd  = 32'd0;
    case (w[31:26])
      6'h00: begin
        wa = w[15:11];
        case (w[5:0])
          6'h21: wd = a + b;
          6'h23: wd = a - b;
          6'h24: wd = a & b;
          6'h25: wd = a | b;
          6'h26: wd = a ^ b;
          6'h27: wd = ~(a | b);
          6'h2a: wd = slt_s(a, b);
          6'h2b: wd = slt_u(a, b);
          6'h00: wd = b << w[10:6];
          6'h02: wd = b >> w[10:6];
          6'h03: wd = shr_a(b, w[10:6]);
          6'h04: wd = b << a[4:0];
          6'h06: wd = b >> a[4:0];
          6'h07: wd = shr_a(b, a[4:0]);
          6'h08: begin npc = a; wa = 5'd0; end
          default: wa = 5'd0;
        endcase
      end
      6'h09: begin wa = w[20:16]; wd = a + se; end
      6'h0c: begin wa = w[20:16]; wd = a & ze; end
      6'h0d: begin wa = w[20:16]; wd = a | ze; end
      6'h0e: begin wa = w[20:16]; wd = a ^ ze; end
      6'h0f: begin wa = w[20:16]; wd = ze << 16; end
      6'h0a: begin wa = w[20:16]; wd = slt_s(a, se); end
      6'h0b: begin wa = w[20:16]; wd = slt_u(a, se); end
      6'h23: begin wa = w[20:16]; wd = m_dmem[ea[11:2]]; end
      6'h2b: m_dmem[ea[11:2]] = b;
      6'h04: if (a == b) npc = m_pc + 32'd4 + se * 4;
      6'h05: if (a != b) npc = m_pc + 32'd4 + se * 4;
      6'h02: npc = {npc[31:28], w[25:0], 2'b00};
      6'h03: begin
        npc = {npc[31:28], w[25:0], 2'b00};
        wa  = 5'd31;
        wd  = m_pc + 32'd4;
      end
`ifdef BRANCH_EXT_EN
      6'h01: begin
        if (w[20:16] == 5'd0 && $signed(a) < 0) npc = m_pc + 32'd4 + se * 4;
        if (w[20:16] == 5'd1 && $signed(a) >= 0) npc = m_pc + 32'd4 + se * 4;
      end
      6'h06: if ($signed(a) <= 0) npc = m_pc + 32'd4 + se * 4;
      6'h07: if ($signed(a) > 0) npc = m_pc + 32'd4 + se * 4;
`endif
      default: ;
    endcase
    if (wa != 5'd0) m_gpr[wa] = wd;
    m_pc = npc;
  endtask

  task automatic put_inst(input int idx, input logic [31:0] v);
    dut.iram_inst.inst_array[idx] = v;
    m_imem[idx] = v;
  endtask

  task automatic put_data(input int idx, input logic [31:0] v);
    dut.dram_inst.data_array[idx] = v;
    m_dmem[idx] = v;
  endtask

  task automatic tick();
    @(posedge clk_in);
    model_tick(reset);
    #1;
  endtask

  function automatic logic [31:0] rand_inst();
    int k;
    logic [31:0] w;
    k = $urandom_range(0, 31);
    w = $urandom;
    if (k < 12) begin
      w[31:26] = 6'h00;
      w[5:0]   = RFUN[$urandom_range(0, 14)];
    end else if (k < 29) begin
      w[31:26] = IOP[$urandom_range(0, 14)];
    end else if (k < 31) begin
      w[31:26] = 6'h01;
      w[20:16] = 5'($urandom_range(0, 2));
    end
    return w;
  endfunction

  always @(negedge clk_in) begin
    if (cmp_en) begin
      chk("pc", pc, m_pc);
      chk("inst", inst, m_imem[m_pc[11:2]]);
      for (int r = 0; r < 32; r++) chk($sformatf("gpr%0d", r), dut.gpr[r], m_gpr[r]);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    cmp_en = 1'b0;
    reset  = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      put_inst(i, 32'd0);
      put_data(i, 32'd0);
    end
    put_inst(0,  32'h2408_0005);
    put_inst(1,  32'h2408_FFFF);
    put_inst(2,  32'h0008_482B);
    put_inst(3,  32'h0008_502A);
    put_inst(4,  32'h1000_0002);
    put_inst(5,  32'h2409_0055);
    put_inst(6,  32'h2409_0055);
    put_inst(7,  32'h0008_5903);
    put_inst(8,  32'h0C10_000C);
    put_inst(9,  32'h3C0C_1234);
    put_inst(10, 32'h358C_5678);
    put_inst(11, 32'h0810_0010);
    put_inst(12, 32'h1400_0005);
    put_inst(13, 32'h2400_0007);
    put_inst(14, 32'hFC00_0000);
    put_inst(15, 32'h03E0_0008);
    put_inst(16, 32'hAC0C_0008);
    put_inst(17, 32'h8C0D_0008);
    put_inst(18, 32'h8C0E_0014);
    put_inst(19, 32'h0500_0001);
    put_inst(20, 32'h240F_0001);
    put_inst(21, 32'h2410_0002);
    put_inst(22, 32'h0810_0016);
    put_data(5, 32'hCAFE_BABE);

    tick();
    cmp_en = 1'b1;
    chk("rst_pc", pc, RPC);
    chk("rst_inst", inst, 32'h2408_0005);
    reset = 1'b0;
    tick();
    chk("t0_5", dut.gpr[8], 32'd5);
    chk("model_t0_5", m_gpr[8], 32'd5);
    chk("pc_plus4", pc, 32'h0040_0004);
    tick();
    chk("addiu_m1", dut.gpr[8], 32'hFFFF_FFFF);
    tick();
    chk("sltu", dut.gpr[9], 32'd1);
    tick();
    chk("slt", dut.gpr[10], 32'd0);
    tick();
    chk("beq_taken", pc, 32'h0040_001C);
    tick();
    chk("sra", dut.gpr[11], 32'hFFFF_FFFF);
    tick();
    chk("jal_ra", dut.gpr[31], 32'h0040_0024);
    chk("jal_pc", pc, 32'h0040_0030);
    chk("model_jal_pc", m_pc, 32'h0040_0030);
    tick();
    chk("bne_equal", pc, 32'h0040_0034);
    tick();
    chk("zero_reg", dut.gpr[0], 32'd0);
    tick();
    chk("unknown_op_pc", pc, 32'h0040_003C);
    tick();
    chk("jr", pc, 32'h0040_0024);
    tick();
    tick();
    chk("lui_ori", dut.gpr[12], 32'h1234_5678);
    tick();
    chk("j", pc, 32'h0040_0040);
    tick();
    chk("sw", dut.dram_inst.data_array[2], 32'h1234_5678);
    tick();
    chk("lw_after_sw", dut.gpr[13], 32'h1234_5678);
    tick();
    chk("lw_preload", dut.gpr[14], 32'hCAFE_BABE);
    tick();
`ifdef BRANCH_EXT_EN
    chk("bltz", pc, 32'h0040_0054);
`else
    chk("bltz", pc, 32'h0040_0050);
`endif
    for (int i = 0; i < 4; i++) tick();
`ifdef BRANCH_EXT_EN
    chk("bltz_skip", dut.gpr[15], 32'd0);
`else
    chk("bltz_skip", dut.gpr[15], 32'd1);
`endif
    chk("after_loop", dut.gpr[16], 32'd2);
    chk("beq_skip", dut.gpr[9], 32'd1);
    reset = 1'b1;
    tick();
    chk("midrst_pc", pc, RPC);
    chk("midrst_gpr", dut.gpr[12], 32'd0);
    chk("midrst_dmem2", dut.dram_inst.data_array[2], 32'h1234_5678);
    chk("midrst_dmem5", dut.dram_inst.data_array[5], 32'hCAFE_BABE);

    for (int i = 0; i < 1024; i++) begin
      put_inst(i, rand_inst());
      put_data(i, $urandom);
    end
    tick();
    for (int n = 0; n < 2000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b1;
    tick();
    for (int i = 0; i < 1024; i++)
      chk($sformatf("dmem%0d", i), dut.dram_inst.data_array[i], m_dmem[i]);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
